// File: rtl/uart_rx_path_if.sv
// Core-facing side of the UART receive path: FIFO read port plus receive status.
interface uart_rx_path_if;
  logic       read_en;
  logic [7:0] data_out;
  logic       rx_fifo_empty;
  logic       rx_fifo_full;
  logic       rx_active_flag;
  logic       rx_done_flag;
  logic [2:0] error_flag;
  logic       overrun_flag;

  modport master (
    output read_en,
    input  data_out, rx_fifo_empty, rx_fifo_full,
    input  rx_active_flag, rx_done_flag, error_flag, overrun_flag
  );

  modport slave (
    input  read_en,
    output data_out, rx_fifo_empty, rx_fifo_full,
    output rx_active_flag, rx_done_flag, error_flag, overrun_flag
  );
endinterface

// File: rtl/uart_rx_path.sv
// UART receive datapath: RX synchronizer, x OVS baud tick generator, bit-level
// receive FSM with parity/start/stop checks, and a first-word-fall-through FIFO.
module uart_rx_path #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int OVS        = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  input  logic       RX,
  uart_rx_path_if.slave core
);

  localparam int DIV0 = CLK_FREQ / (2400  * OVS);
  localparam int DIV1 = CLK_FREQ / (4800  * OVS);
  localparam int DIV2 = CLK_FREQ / (9600  * OVS);
  localparam int DIV3 = CLK_FREQ / (19200 * OVS);
  localparam int DW   = $clog2(DIV0 + 1);
  localparam int TW   = $clog2(OVS);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] T_A    = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_B    = TW'(OVS/2);
  localparam logic [TW-1:0] T_MID  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          rx_s1, rx_s2, rx_s3;
  logic          start_edge;
  logic [1:0]    baud_q, par_q;
  logic [DW-1:0] div_cnt, div_last;
  logic          tick;
  logic [TW-1:0] tick_cnt;
  logic          s_a, s_b, maj;
  logic          mid_tick, end_tick;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_err;
  logic          rx_active, rx_done;
  logic [2:0]    err_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, wr_req, wr_ok, pop_ok, overrun;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) {rx_s3, rx_s2, rx_s1} <= 3'b111;
    else          {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, RX};
  end

  assign start_edge = rx_s3 & ~rx_s2;

  always_comb begin
    div_last = '0;
    case (baud_q)
      2'b00:   div_last = DW'(DIV0 - 1);
      2'b01:   div_last = DW'(DIV1 - 1);
      2'b10:   div_last = DW'(DIV2 - 1);
      default: div_last = DW'(DIV3 - 1);
    endcase
  end

  assign tick = (div_cnt == div_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         div_cnt <= '0;
    else if ((state == IDLE) && start_edge) div_cnt <= '0;
    else if (tick)                        div_cnt <= '0;
    else                                  div_cnt <= div_cnt + 1'b1;
  end

  assign mid_tick = tick && (tick_cnt == T_MID);
  assign end_tick = tick && (tick_cnt == T_LAST);
  assign maj      = (s_a & s_b) | (s_a & rx_s2) | (s_b & rx_s2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_q    <= 2'b00;
      par_q     <= 2'b00;
      tick_cnt  <= '0;
      s_a       <= 1'b0;
      s_b       <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      par_err   <= 1'b0;
      rx_active <= 1'b0;
      rx_done   <= 1'b0;
      err_q     <= 3'b000;
    end else begin
      rx_done <= 1'b0;
      if (state != IDLE && tick) begin
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == T_A) s_a <= rx_s2;
        if (tick_cnt == T_B) s_b <= rx_s2;
      end
      case (state)
        IDLE: if (start_edge) begin
          state     <= START;
          rx_active <= 1'b1;
          baud_q    <= baud_rate;
          par_q     <= parity_type;
          tick_cnt  <= '0;
          bit_cnt   <= 3'd0;
          par_err   <= 1'b0;
        end
        START: begin
          if (mid_tick && maj) begin
            state     <= IDLE;
            rx_active <= 1'b0;
            rx_done   <= 1'b1;
            err_q     <= 3'b010;
          end else if (end_tick) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (mid_tick) shreg <= {maj, shreg[7:1]};
          if (end_tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (^par_q) ? PARITY : STOP;
          end
        end
        PARITY: begin
          // par_q[0] is 1 for odd: an odd frame needs XOR(data, parity) = 1.
          if (mid_tick) par_err <= (^shreg) ^ maj ^ par_q[0];
          if (end_tick) state <= STOP;
        end
        STOP: if (mid_tick) begin
          // Close the frame at mid-stop so a back-to-back start edge is not missed.
          state     <= IDLE;
          rx_active <= 1'b0;
          rx_done   <= 1'b1;
          err_q     <= {~maj, 1'b0, par_err};
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok = core.read_en & ~empty;
  assign wr_req = rx_done & (err_q == 3'b000);
  assign wr_ok  = wr_req & (~full | pop_ok);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr              <= wptr + 1'b1;
      end
      if (pop_ok) rptr <= rptr + 1'b1;
      if (wr_req && !wr_ok) overrun <= 1'b1;
      else if (pop_ok)      overrun <= 1'b0;
    end
  end

  assign core.data_out       = mem[rptr[AW-1:0]];
  assign core.rx_fifo_empty  = empty;
  assign core.rx_fifo_full   = full;
  assign core.rx_active_flag = rx_active;
  assign core.rx_done_flag   = rx_done;
  assign core.error_flag     = err_q;
  assign core.overrun_flag   = overrun;

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed bench for uart_rx_path at 1.8432 MHz / 9600 baud (192 clocks per bit).
module tb_uart_rx_path;
  localparam int BIT = 192;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] parity_type, baud_rate;
  logic       RX;
  int         checks = 0, errors = 0;
  int         exp_done = 0;

  int         done_cnt = 0;
  logic [2:0] err_at_done;
  logic       empty_at_done, empty_after, pend = 1'b0;
  logic [7:0] data_after;

  uart_rx_path_if bus();

  uart_rx_path #(.CLK_FREQ(1_843_200), .FIFO_DEPTH(8), .OVS(16)) dut (
    .clock(clock), .reset_n(reset_n), .parity_type(parity_type),
    .baud_rate(baud_rate), .RX(RX), .core(bus)
  );

  always #5 clock = ~clock;

  // Records each done pulse and the FIFO head one cycle later.
  always @(negedge clock) begin
    if (pend) begin
      empty_after <= bus.rx_fifo_empty;
      data_after  <= bus.data_out;
      pend        <= 1'b0;
    end
    if (bus.rx_done_flag) begin
      done_cnt      <= done_cnt + 1;
      err_at_done   <= bus.error_flag;
      empty_at_done <= bus.rx_fifo_empty;
      pend          <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop_bit);
    @(posedge clock); #1;
    RX = 1'b0; hold(BIT);
    for (int i = 0; i < 8; i++) begin RX = d[i]; hold(BIT); end
    if (par_en) begin RX = par_bit; hold(BIT); end
    RX = stop_bit; hold(BIT);
    RX = 1'b1; hold(20);
    @(negedge clock);
  endtask

  task automatic pop;
    @(posedge clock); #1;
    bus.read_en = 1'b1;
    @(posedge clock); #1;
    bus.read_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic frame_ok(input string tag, input logic [7:0] d);
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_err"}, err_at_done, 3'b000);
    chk({tag, "_data"}, data_after, d);
    chk({tag, "_empty_after"}, empty_after, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; RX = 1'b1; bus.read_en = 1'b0;
    parity_type = 2'b00; baud_rate = 2'b10;
    repeat (3) @(negedge clock);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_empty", bus.rx_fifo_empty, 1'b1);
    chk("rst_full", bus.rx_fifo_full, 1'b0);
    chk("rst_active", bus.rx_active_flag, 1'b0);
    chk("rst_done", bus.rx_done_flag, 1'b0);
    chk("rst_err", bus.error_flag, 3'b000);
    chk("rst_ovr", bus.overrun_flag, 1'b0);
    @(posedge clock); #1; reset_n = 1'b1; hold(5);

    // 1: plain 8N1 frame, one-cycle write latency after done
    send(8'hA5, 1'b0, 1'b0, 1'b1); exp_done++;
    frame_ok("t1", 8'hA5);
    chk("t1_empty_at_done", empty_at_done, 1'b1);
    chk("t1_active", bus.rx_active_flag, 1'b0);
    pop;
    chk("t1_empty_pop", bus.rx_fifo_empty, 1'b1);

    // 2: even parity, 0x3C has even weight so the correct parity bit is 0
    parity_type = 2'b10;
    send(8'h3C, 1'b1, 1'b1, 1'b1); exp_done++;
    chk("t2_bad_done", done_cnt, exp_done);
    chk("t2_bad_err", err_at_done, 3'b001);
    chk("t2_bad_empty", bus.rx_fifo_empty, 1'b1);
    send(8'h3C, 1'b1, 1'b0, 1'b1); exp_done++;
    frame_ok("t2", 8'h3C);
    pop;

    // 3: 48-clock glitch is a false start
    parity_type = 2'b00;
    @(posedge clock); #1;
    RX = 1'b0; hold(48); RX = 1'b1; hold(2);
    chk("t3_active", bus.rx_active_flag, 1'b1);
    hold(300); @(negedge clock);
    exp_done++;
    chk("t3_done", done_cnt, exp_done);
    chk("t3_err", bus.error_flag, 3'b010);
    chk("t3_active_off", bus.rx_active_flag, 1'b0);
    chk("t3_empty", bus.rx_fifo_empty, 1'b1);

    // 4: stop-bit error, then a good frame
    send(8'h55, 1'b0, 1'b0, 1'b0); exp_done++;
    chk("t4_bad_done", done_cnt, exp_done);
    chk("t4_bad_err", err_at_done, 3'b100);
    chk("t4_bad_empty", bus.rx_fifo_empty, 1'b1);
    send(8'h0F, 1'b0, 1'b0, 1'b1); exp_done++;
    frame_ok("t4", 8'h0F);
    pop;

    // 5: fill, overrun, drain
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 1'b0, 1'b0, 1'b1); exp_done++;
    end
    chk("t5_full", bus.rx_fifo_full, 1'b1);
    chk("t5_ovr_pre", bus.overrun_flag, 1'b0);
    send(8'h08, 1'b0, 1'b0, 1'b1); exp_done++;
    chk("t5_done", done_cnt, exp_done);
    chk("t5_err", err_at_done, 3'b000);
    chk("t5_ovr", bus.overrun_flag, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t5_pop_data", bus.data_out, 32'(i));
      pop;
      if (i == 0) begin
        chk("t5_ovr_clr", bus.overrun_flag, 1'b0);
        chk("t5_not_full", bus.rx_fifo_full, 1'b0);
      end
    end
    chk("t5_empty", bus.rx_fifo_empty, 1'b1);

    // 6: reset during data bit 4 wipes FIFO and frame
    send(8'h7E, 1'b0, 1'b0, 1'b1); exp_done++;
    frame_ok("t6_pre", 8'h7E);
    @(posedge clock); #1;
    RX = 1'b0; hold(BIT);
    RX = 1'b1; hold(BIT);
    RX = 1'b0; hold(3 * BIT);
    hold(BIT / 2);
    chk("t6_active", bus.rx_active_flag, 1'b1);
    reset_n = 1'b0; #1;
    chk("t6_rst_data", bus.data_out, 8'h00);
    chk("t6_rst_empty", bus.rx_fifo_empty, 1'b1);
    chk("t6_rst_full", bus.rx_fifo_full, 1'b0);
    chk("t6_rst_active", bus.rx_active_flag, 1'b0);
    chk("t6_rst_done", bus.rx_done_flag, 1'b0);
    chk("t6_rst_err", bus.error_flag, 3'b000);
    chk("t6_rst_ovr", bus.overrun_flag, 1'b0);
    RX = 1'b1; hold(5);
    reset_n = 1'b1; hold(5);
    send(8'h81, 1'b0, 1'b0, 1'b1); exp_done++;
    frame_ok("t6", 8'h81);
    chk("t6_head", bus.data_out, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
